// File: rtl/hazard_pipe_regs.sv
// PC, IF/ID, ID/EX and EX/MEM control latches feeding the hazard detection unit.
// Optional saturating stall/flush/bubble counters when HAZARD_PERF_CNT_EN is defined.
module hazard_pipe_regs #(
    parameter int unsigned        WORD_W  = 32,
    parameter logic [WORD_W-1:0]  PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic [WORD_W-1:0] pc_next,
    input  logic              mem_ready,
    input  logic              pc_wen,
    input  logic              stall_ifid,
    input  logic              flush_ifid,
    input  logic              flush_idex,
    input  logic              regwr_id,
    input  logic              br_taken_ex,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] instr_id,
    output logic [WORD_W-1:0] pcp4_id,
    output logic [4:0]        Rs_id,
    output logic [4:0]        Rt_id,
    output logic              jump_id,
    output logic [4:0]        Rt_ex,
    output logic              jump_ex,
    output logic              dREN_ex,
    output logic              dWEN_ex,
    output logic              branch_mem,
    output logic              RegWr_mem
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pcp4_q, pcp4_d;
    logic              vid_q, vid_d;
    logic [4:0]        rt_ex_q, rt_ex_d;
    logic              jex_q, jex_d;
    logic              dren_q, dren_d;
    logic              dwen_q, dwen_d;
    logic              regwr_ex_q, regwr_ex_d;
    logic              vex_q, vex_d;
    logic              brm_q, brm_d;
    logic              rwm_q, rwm_d;

    logic [5:0] op_id;
    logic [5:0] funct_id;

    assign op_id    = instr_q[31:26];
    assign funct_id = instr_q[5:0];
    assign Rs_id    = instr_q[25:21];
    assign Rt_id    = instr_q[20:16];
    assign jump_id  = vid_q && (op_id == OP_J || op_id == OP_JAL ||
                                (op_id == OP_RTYPE && funct_id == FN_JR));

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pcp4_d     = pcp4_q;
        vid_d      = vid_q;
        rt_ex_d    = rt_ex_q;
        jex_d      = jex_q;
        dren_d     = dren_q;
        dwen_d     = dwen_q;
        regwr_ex_d = regwr_ex_q;
        vex_d      = vex_q;
        brm_d      = brm_q;
        rwm_d      = rwm_q;

        if (pc_wen && ihit && mem_ready)
            pc_d = pc_next;

        // Every stage freezes while a data access is outstanding.
        if (mem_ready) begin
            if (flush_ifid) begin
                instr_d = '0;
                vid_d   = 1'b0;
            end else if (!stall_ifid) begin
                if (ihit) begin
                    instr_d = imemload;
                    pcp4_d  = pc_q + WORD_W'(4);
                    vid_d   = 1'b1;
                end else begin
                    instr_d = '0;
                    vid_d   = 1'b0;
                end
            end

            if (flush_idex) begin
                rt_ex_d    = '0;
                jex_d      = 1'b0;
                dren_d     = 1'b0;
                dwen_d     = 1'b0;
                regwr_ex_d = 1'b0;
                vex_d      = 1'b0;
            end else begin
                rt_ex_d    = vid_q ? Rt_id : 5'd0;
                jex_d      = jump_id;
                dren_d     = vid_q && (op_id == OP_LW);
                dwen_d     = vid_q && (op_id == OP_SW);
                regwr_ex_d = vid_q && regwr_id;
                vex_d      = vid_q;
            end

            brm_d = br_taken_ex && vex_q;
            rwm_d = regwr_ex_q && vex_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q       <= PC_INIT;
            instr_q    <= '0;
            pcp4_q     <= '0;
            vid_q      <= 1'b0;
            rt_ex_q    <= '0;
            jex_q      <= 1'b0;
            dren_q     <= 1'b0;
            dwen_q     <= 1'b0;
            regwr_ex_q <= 1'b0;
            vex_q      <= 1'b0;
            brm_q      <= 1'b0;
            rwm_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pcp4_q     <= pcp4_d;
            vid_q      <= vid_d;
            rt_ex_q    <= rt_ex_d;
            jex_q      <= jex_d;
            dren_q     <= dren_d;
            dwen_q     <= dwen_d;
            regwr_ex_q <= regwr_ex_d;
            vex_q      <= vex_d;
            brm_q      <= brm_d;
            rwm_q      <= rwm_d;
        end
    end

    assign pc         = pc_q;
    assign instr_id   = instr_q;
    assign pcp4_id    = pcp4_q;
    assign Rt_ex      = rt_ex_q;
    assign jump_ex    = jex_q;
    assign dREN_ex    = dren_q;
    assign dWEN_ex    = dwen_q;
    assign branch_mem = brm_q;
    assign RegWr_mem  = rwm_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, bubble_cnt_q;
    logic        bubble_load;

    assign bubble_load = mem_ready && !flush_ifid && !stall_ifid && !ihit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall_ifid && mem_ready && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if ((flush_ifid || flush_idex) && mem_ready && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 32'd1;
            if (bubble_load && bubble_cnt_q != '1)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/hazard_pipe_regs.md
Name: hazard_pipe_regs

Overview:
- Front-end pipeline register bank: PC, IF/ID, ID/EX and EX/MEM control latches.
- Consumes the hazard unit's control outputs: pc_wen, stall_ifid, flush_ifid, flush_idex.
- Produces the stage-tagged fields the hazard unit samples: Rs_id, Rt_id, Rt_ex, jump_id, jump_ex, dREN_ex, dWEN_ex, branch_mem, RegWr_mem.
- Sits between fetch/decode logic and the hazard detection unit in the 5-stage MIPS datapath.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, instruction/PC width

Ports:
CLK  in  1  system clock, all state rising-edge
RST  in  1  synchronous active-high reset
ihit  in  1  instruction cache hit; fetch word valid this cycle
imemload  in  WORD_W  fetched instruction
pc_next  in  WORD_W  next-PC from PC mux
mem_ready  in  1  global advance enable; low while a data access is pending (no dhit)
pc_wen  in  1  hazard unit: PC may update
stall_ifid  in  1  hazard unit: hold IF/ID
flush_ifid  in  1  hazard unit: bubble IF/ID
flush_idex  in  1  hazard unit: bubble ID/EX
regwr_id  in  1  control unit RegWr for instruction in ID
br_taken_ex  in  1  branch resolved taken in EX
pc  out  WORD_W  current fetch PC
instr_id  out  WORD_W  IF/ID instruction
pcp4_id  out  WORD_W  IF/ID PC+4
Rs_id  out  5  instr_id[25:21]
Rt_id  out  5  instr_id[20:16]
jump_id  out  1  valid J/JAL/JR in ID
Rt_ex  out  5  ID/EX Rt
jump_ex  out  1  ID/EX jump flag
dREN_ex  out  1  ID/EX load (op 100011)
dWEN_ex  out  1  ID/EX store (op 101011)
branch_mem  out  1  EX/MEM taken-branch flag
RegWr_mem  out  1  EX/MEM register-write flag

Behaviour:
- Reset (RST high at an edge): pc=PC_INIT; all IF/ID, ID/EX, EX/MEM latches and valid bits 0; instr_id=0 (NOP). All outputs 0 except pc. Reset overrides every other input, including mid-stall.
- PC: pc <= pc_next when pc_wen && ihit && mem_ready; otherwise holds.
- IF/ID, one-cycle latency. Priority order, evaluated only when mem_ready=1:
  - flush_ifid -> instr_id=0, v_id=0.
  - else stall_ifid -> hold.
  - else ihit -> instr_id=imemload, pcp4_id=pc+4, v_id=1.
  - else (no ihit) -> bubble, v_id=0.
- If mem_ready=0, IF/ID holds regardless of flush/stall. A flush arriving while mem_ready=0 is not remembered; the hazard unit must hold it until mem_ready rises.
- ID/EX, when mem_ready=1:
  - flush_idex -> all fields 0 (bubble).
  - else capture decode of instr_id gated by v_id:
    - jump_ex = jump_id.
    - dREN_ex/dWEN_ex from opcode.
    - Rt_ex = Rt_id.
    - regwr captured from regwr_id.
  - Holds when mem_ready=0.
- EX/MEM, when mem_ready=1: branch_mem <= br_taken_ex && v_ex; RegWr_mem <= regwr_ex && v_ex. Holds when mem_ready=0.
- jump_id: combinational = v_id && (op==000010 || op==000011 || (op==000000 && funct==001000)).
- Rs_id/Rt_id: combinational slices of instr_id. They read 0 when a bubble is present.
- Simultaneous flush_ifid and flush_idex: both stages bubble in the same edge.
- Simultaneous stall_ifid and flush_idex (load-use case): IF/ID holds and ID/EX bubbles. pc_wen is expected low in this case.
- PC+4 arithmetic wraps modulo 2^WORD_W.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cnt[31:0], flush_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments on cycles with stall_ifid && mem_ready.
  - flush_cnt increments on cycles with (flush_ifid || flush_idex) && mem_ready; a simultaneous dual flush counts once.
  - bubble_cnt increments on cycles where IF/ID loads a bubble due to !ihit.
  - All counters saturate at 32'hFFFF_FFFF and clear on RST.
- Undefined: the ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset then RST=0, ihit=1, pc_next=pc+4, imemload=lw $2,0($1) (0x8C220000) -> after 1 edge instr_id=0x8C220000, Rs_id=1, Rt_id=2; after 2 edges dREN_ex=1, Rt_ex=2.
- Load-use: stall_ifid=1, flush_idex=1, pc_wen=0 for 1 cycle -> pc and instr_id unchanged; next edge dREN_ex=0, dWEN_ex=0, Rt_ex=0.
- Jump: instr_id=0x08000010 (J) -> jump_id=1. Assert flush_ifid -> next edge instr_id=0, jump_id=0, jump_ex=1.
- Memory stall: mem_ready=0 for 3 cycles with ihit=1 and new imemload -> pc, instr_id, Rt_ex and branch_mem all hold. mem_ready=1 -> pipeline advances one stage.
- Branch: br_taken_ex=1 with a valid EX instruction -> branch_mem=1 next edge. Assert flush_ifid+flush_idex together -> both stages read 0 next edge.
- Assert RST during a stall with branch_mem=1 -> next edge pc=PC_INIT and all outputs 0. With HAZARD_PERF_CNT_EN defined, counters also read 0.
